// File: rtl/param_updown_counter.sv
// param_updown_counter: debounced push-button up/down modulo counter with load and terminal-count pulse; define SATURATE_EN to saturate instead of wrap
module param_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MOD       = 16,
  parameter int RESET_VAL = 15,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             pressed
);
  localparam int DBW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0]   DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] CMAX    = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RV      = WIDTH'(RESET_VAL);
`ifdef SATURATE_EN
  localparam logic [WIDTH-1:0] WRAP_UP = CMAX;
  localparam logic [WIDTH-1:0] WRAP_DN = '0;
`else
  localparam logic [WIDTH-1:0] WRAP_UP = '0;
  localparam logic [WIDTH-1:0] WRAP_DN = CMAX;
`endif
  logic             s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic             pressed_q, pressed_d, tc_q, tc_d, step, at_max, at_min;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic [WIDTH-1:0] count_q, count_d;
  assign step    = pressed_q & ~prev_q;
  assign at_max  = count_q == CMAX;
  assign at_min  = count_q == '0;
  assign count   = count_q;
  assign tc      = tc_q;
  assign pressed = pressed_q;
  always_comb begin
    s1_d      = btn;
    s2_d      = s1_q;
    prev_d    = pressed_q;
    pressed_d = pressed_q;
    db_cnt_d  = '0;
    if (s2_q != pressed_q) begin
      if (db_cnt_q == DB_LAST) pressed_d = s2_q;
      else db_cnt_d = db_cnt_q + DBW'(1);
    end
  end
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) count_d = ({1'b0, load_val} >= MOD_W) ? CMAX : load_val;
    else if (step && up) begin
      tc_d    = at_max;
      count_d = at_max ? WRAP_UP : count_q + WIDTH'(1);
    end else if (step) begin
      tc_d    = at_min;
      count_d = at_min ? WRAP_DN : count_q - WIDTH'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      prev_q    <= 1'b0;
      pressed_q <= 1'b0;
      db_cnt_q  <= '0;
      count_q   <= RV;
      tc_q      <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      prev_q    <= prev_d;
      pressed_q <= pressed_d;
      db_cnt_q  <= db_cnt_d;
      count_q   <= count_d;
      tc_q      <= tc_d;
    end
  end
endmodule
